// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: frame sequencer for the VGA demo datapath.
// Owns the h/v pixel counters and produces registered sync, data-enable,
// coordinates and line/frame pulses. Mode/enable changes arrive through a
// one-deep valid/ready slot and take effect only at a frame boundary.
module vga_timing_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [2:0] cfg_mode,
    input  logic       cfg_enable,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frame_start,
    output logic       line_start,
    output logic [2:0] mode,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [1:0] rst_sync_q;   // release synchronizer for reset_n
    logic       run_q;        // counters are running
    logic [9:0] h_q, v_q;     // position currently shown on the outputs
    logic [2:0] pend_mode_q;
    logic       pend_en_q;
    logic       enable_q;     // applied video enable

    logic       start;        // first edge after synchronized release
    logic       frame_wrap;   // edge that wraps (H_TOTAL-1,V_TOTAL-1) -> (0,0)
    logic       step;         // outputs move to a new position on this edge
    logic       apply;        // pending config becomes active on this edge
    logic       accept;       // handshake completes on this edge
    logic [9:0] h_nxt, v_nxt;
    logic       en_nxt;
    logic       de_nxt;

    assign start      = ~run_q & rst_sync_q[1];
    assign frame_wrap = run_q & (h_q == H_LAST) & (v_q == V_LAST);
    assign step       = run_q | start;
    // cfg_ready doubles as the "slot empty" flag, so the slot is pending when it is low.
    assign apply      = (start | frame_wrap) & ~cfg_ready;
    assign accept     = cfg_valid & cfg_ready;

    // Next counter position and the video enable that will govern it.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        h_nxt  = h_q;
        v_nxt  = v_q;
        en_nxt = apply ? pend_en_q : enable_q;
        if (start) begin
            h_nxt = '0;
            v_nxt = '0;
        end else if (run_q) begin
            if (h_q == H_LAST) begin
                h_nxt = '0;
                v_nxt = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
            end else begin
                h_nxt = h_q + 10'd1;
            end
        end
        de_nxt = en_nxt & (h_nxt < H_ACT) & (v_nxt < V_ACT);
    end

    // Reset release synchronizer and run flag; assertion stays asynchronous.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            rst_sync_q <= 2'b00;
            run_q      <= 1'b0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
            run_q      <= run_q | rst_sync_q[1];
        end
    end

    // Config slot: accept when empty, hand over to the applied registers at frame start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_ready   <= 1'b1;
            pend_mode_q <= 3'd0;
            pend_en_q   <= 1'b0;
            mode        <= 3'd0;
            enable_q    <= 1'b1;
        end else if (apply) begin
            cfg_ready <= 1'b1;
            mode      <= pend_mode_q;
            enable_q  <= pend_en_q;
        end else if (accept) begin
            cfg_ready   <= 1'b0;
            pend_mode_q <= cfg_mode;
            pend_en_q   <= cfg_enable;
        end
    end

    // Counters and every timing output, registered from the next position.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_q         <= '0;
            v_q         <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            frame_count <= '0;
        end else if (step) begin
            h_q         <= h_nxt;
            v_q         <= v_nxt;
            hsync       <= ~((h_nxt >= HS_BEG) && (h_nxt < HS_END));
            vsync       <= ~((v_nxt >= VS_BEG) && (v_nxt < VS_END));
            de          <= de_nxt;
            x           <= de_nxt ? h_nxt : 10'd0;
            y           <= de_nxt ? v_nxt : 10'd0;
            frame_start <= (h_nxt == 10'd0) && (v_nxt == 10'd0);
            line_start  <= (h_nxt == 10'd0);
            if (frame_wrap) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Testbench for vga_timing_ctrl with reduced timing (H 8/2/2/2, V 4/1/1/1).
// A driver advances a position-arithmetic reference model each cycle, pushes
// the expected outputs into a queue and issues random/directed config
// requests; a monitor on the falling edge pops and compares.
module tb_vga_timing_ctrl;

    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;   // 14
    localparam int VT = VA + VF + VS + VB;   // 7
    localparam int FT = HT * VT;             // 98 clocks per frame

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       cfg_valid = 1'b0;
    logic [2:0] cfg_mode = 3'd0;
    logic       cfg_enable = 1'b0;
    logic       cfg_ready;
    logic       hsync, vsync, de, frame_start, line_start;
    logic [9:0] x, y;
    logic [2:0] mode;
    logic [7:0] frame_count;

    vga_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_mode(cfg_mode), .cfg_enable(cfg_enable),
        .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
        .frame_start(frame_start), .line_start(line_start),
        .mode(mode), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic       hsync, vsync, de, fs, ls, ready;
        logic [9:0] x, y;
        logic [2:0] mode;
        logic [7:0] fc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    // Reference model state: applied config and one pending request.
    logic [2:0] m_mode;
    logic       m_en;
    bit         p_valid;
    logic [2:0] p_mode;
    logic       p_en;
    int         p_frame;
    int         cur_frame, cur_pos;

    task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: compare whatever the driver predicted for this cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("hsync",       mon_e.cyc, 32'(hsync),       32'(mon_e.hsync));
            check("vsync",       mon_e.cyc, 32'(vsync),       32'(mon_e.vsync));
            check("de",          mon_e.cyc, 32'(de),          32'(mon_e.de));
            check("x",           mon_e.cyc, 32'(x),           32'(mon_e.x));
            check("y",           mon_e.cyc, 32'(y),           32'(mon_e.y));
            check("frame_start", mon_e.cyc, 32'(frame_start), 32'(mon_e.fs));
            check("line_start",  mon_e.cyc, 32'(line_start),  32'(mon_e.ls));
            check("mode",        mon_e.cyc, 32'(mode),        32'(mon_e.mode));
            check("frame_count", mon_e.cyc, 32'(frame_count), 32'(mon_e.fc));
            check("cfg_ready",   mon_e.cyc, 32'(cfg_ready),   32'(mon_e.ready));
        end
    end

    task automatic model_reset();
        m_mode  = 3'd0;
        m_en    = 1'b1;
        p_valid = 1'b0;
    endtask

    // Expected outputs for cycle t counted from the first frame_start.
    task automatic model_cycle(input int t);
        exp_t e;
        int   h, v;
        cur_frame = t / FT;
        cur_pos   = t % FT;
        h = cur_pos % HT;
        v = cur_pos / HT;
        if (p_valid && cur_frame == p_frame && cur_pos == 0) begin
            m_mode  = p_mode;
            m_en    = p_en;
            p_valid = 1'b0;
        end
        e.cyc   = t;
        e.hsync = !(h >= HA + HF && h < HA + HF + HS);
        e.vsync = !(v >= VA + VF && v < VA + VF + VS);
        e.de    = m_en && h < HA && v < VA;
        e.x     = e.de ? 10'(h) : 10'd0;
        e.y     = e.de ? 10'(v) : 10'd0;
        e.fs    = (cur_pos == 0);
        e.ls    = (h == 0);
        e.mode  = m_mode;
        e.fc    = 8'(cur_frame);
        e.ready = !p_valid;
        exp_q.push_back(e);
    endtask

    // Drive one request; the model accepts it only if the slot is empty.
    task automatic drive(input bit valid, input logic [2:0] md, input logic en);
        cfg_valid  = valid;
        cfg_mode   = md;
        cfg_enable = en;
        if (valid && !p_valid) begin
            p_valid = 1'b1;
            p_mode  = md;
            p_en    = en;
            // Acceptance in the last cycle of a frame skips the very next frame start.
            p_frame = (cur_pos == FT - 1) ? cur_frame + 2 : cur_frame + 1;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_hsync"},       0, 32'(hsync),       32'd1);
        check({tag, "_vsync"},       0, 32'(vsync),       32'd1);
        check({tag, "_de"},          0, 32'(de),          32'd0);
        check({tag, "_x"},           0, 32'(x),           32'd0);
        check({tag, "_y"},           0, 32'(y),           32'd0);
        check({tag, "_frame_start"}, 0, 32'(frame_start), 32'd0);
        check({tag, "_line_start"},  0, 32'(line_start),  32'd0);
        check({tag, "_mode"},        0, 32'(mode),        32'd0);
        check({tag, "_cfg_ready"},   0, 32'(cfg_ready),   32'd1);
        check({tag, "_frame_count"}, 0, 32'(frame_count), 32'd0);
    endtask

    task automatic wait_frame_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (frame_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL start_timeout: frame_start not seen within 10 cycles of release, required within 10");
        end
    endtask

    // Run n cycles from a frame start; phase 1 carries the directed cases.
    task automatic run_phase(input int n, input bit phase1);
        bit         valid;
        logic [2:0] md;
        logic       en;
        bit         rnd_on;
        for (int t = 0; t < n; t++) begin
            if (t > 0) begin
                @(posedge clk);
                #1;
            end
            model_cycle(t);
            md     = 3'($urandom_range(0, 7));
            en     = ($urandom_range(0, 3) != 0);
            rnd_on = !(phase1 && ((cur_frame >= 10 && cur_frame <= 13) || cur_frame >= 261));
            valid  = rnd_on && ($urandom_range(0, 19) == 0);
            if (phase1) begin
                // Last cycle of frame 10: disable video, lands at frame 12.
                if (cur_frame == 10 && cur_pos == FT - 1) begin valid = 1'b1; md = 3'd5; en = 1'b0; end
                // Slot still full: this request must be dropped.
                if (cur_frame == 11 && cur_pos == 20)     begin valid = 1'b1; md = 3'd2; en = 1'b1; end
                // Re-enable during the dark frame, lands at frame 13.
                if (cur_frame == 12 && cur_pos == 30)     begin valid = 1'b1; md = 3'd3; en = 1'b1; end
                // Left pending when reset hits mid-frame.
                if (cur_frame == 262 && cur_pos == 10)    begin valid = 1'b1; md = 3'd6; en = 1'b0; end
            end
            drive(valid, md, en);
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        bit ok;
        #2;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("rst0");
        @(negedge clk);
        reset_n = 1'b1;
        wait_frame_start(ok);
        if (ok) begin
            model_reset();
            // Long enough to carry frame_count through 255 -> 0.
            run_phase(262 * FT + 45, 1'b1);
            @(negedge clk);
            #1;
            cfg_valid = 1'b0;
            reset_n   = 1'b0;
            #1;
            check_reset_values("rst_mid");
            repeat (3) @(negedge clk);
            #1;
            check_reset_values("rst_hold");
            reset_n = 1'b1;
            wait_frame_start(ok);
            if (ok) begin
                model_reset();
                run_phase(3 * FT, 1'b0);
            end
        end
        cfg_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

Frame sequencer for the VGA demo datapath. It owns the horizontal and vertical pixel counters and generates hsync, vsync, data-enable and pixel coordinates. It accepts mode/enable configuration from the LA interface through a valid/ready handshake and applies each change only at a frame boundary, so the pixel generator never sees a mid-frame mode switch. It sits between the Caravel-side control signals and the demo pattern generator, which drives `io_out[24:11]`.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (clocks)
- `H_SYNC`, 96, hsync pulse width
- `H_BP`, 48, horizontal back porch
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width
- `V_BP`, 33, vertical back porch
- `clk  in  1  pixel clock (wb_clk_i)`
- `reset_n  in  1  asynchronous, active-low reset`
- `cfg_valid  in  1  config request`
- `cfg_ready  out  1  pending-config slot empty`
- `cfg_mode  in  3  demo pattern select`
- `cfg_enable  in  1  video enable`
- `hsync  out  1  horizontal sync, active low`
- `vsync  out  1  vertical sync, active low`
- `de  out  1  active-video data enable`
- `x  out  10  pixel column, 0..H_ACTIVE-1 while de`
- `y  out  10  pixel row, 0..V_ACTIVE-1 while de`
- `frame_start  out  1  one-cycle pulse at (h,v)=(0,0)`
- `line_start  out  1  one-cycle pulse at h=0`
- `mode  out  3  currently applied mode`
- `frame_count  out  8  frames since reset, wraps`

## Operation
- H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL likewise (525). Both must be ≤1024; counters are 10 bits.
- h increments every clk. At H_TOTAL-1, h wraps to 0 and v increments. At (H_TOTAL-1, V_TOTAL-1), both wrap to 0.
- All outputs are registered, glitch-free, and describe the current counter pair (h,v) in the same cycle.
- hsync=0 iff H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC (656..751). vsync=0 iff V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC (490..491).
- de = enable_applied & (h<H_ACTIVE) & (v<V_ACTIVE). x=h and y=v while de; x=y=0 otherwise.
- line_start=1 iff h=0. frame_start=1 iff h=0 and v=0.
- Sync, counters and pulses run regardless of enable.
- Config slot is a single pending register plus a flag:
  - cfg_ready = !pending.
  - On cfg_valid&cfg_ready, the slot latches cfg_mode and cfg_enable, and pending=1.
  - cfg_valid while cfg_ready=0 is ignored and not queued; the requester holds.
- Apply: on the clock edge that wraps counters to (0,0), if pending was 1 before that edge, mode/enable_applied take the pending values and pending clears.
  - frame_start and the first de pixel of that frame already use the new values.
  - cfg_ready is 1 in the first cycle of the new frame.
- Boundary case: a request accepted in the last cycle of a frame (h=H_TOTAL-1, v=V_TOTAL-1) is latched at that edge but not applied. It applies at the following frame start.
- frame_count increments on every wrap to (0,0); 255→0.

## Timing
- Reset (async assert, sync-released internally to the clk domain):
  - h=v=0; hsync=1, vsync=1, de=0, x=y=0, frame_start=0, line_start=0.
  - mode=0, enable_applied=1, pending=0, cfg_ready=1, frame_count=0.
- First cycle after reset_n release: h=v=0, de=1, frame_start=1, line_start=1.
- Reset asserted mid-frame: all outputs return to reset values immediately. Any pending config is discarded.
- Config latency: from acceptance to application, at most one frame plus one cycle. There is no combinational path from cfg_valid to cfg_ready.
- Line period is H_TOTAL clks. Frame period is H_TOTAL·V_TOTAL clks (420000).

## Test plan
- Use small parameters (H 8/2/2/2, V 4/1/1/1) for fast runs. Release reset → cycle 0: frame_start=1, de=1, x=0, y=0. hsync=0 exactly at h=10..11. Line period 14 clks. vsync=0 at v=5.
- Default parameters: count clks between frame_start pulses → exactly 420000. hsync low for 96 clks starting at h=656. vsync low for 1600 clks.
- Accept cfg_mode=5, enable=1 at v=100 → cfg_ready=0 until the next frame start. mode=5 in the frame_start cycle. cfg_ready=1 in that same cycle.
- Assert cfg_valid in the last cycle of the frame → accepted, but mode is unchanged at the next frame_start and changes at the one after. A second request while cfg_ready=0 is not accepted.
- Config enable=0 → after apply, de=0 for the entire frame while hsync/vsync/frame_start still toggle. Re-enable → de resumes at the next frame.
- Pulse reset_n low at h=300, v=200 with a config pending → outputs are at reset values during reset. After release, frame_start=1, mode=0, cfg_ready=1, frame_count=0.
